// File: rtl/code_mem_loader_pkg.sv
// Shared definitions for the writable code memory: loader FSM states and
// read-word sizing.
package code_mem_loader_pkg;

  typedef enum logic [1:0] {
    LOADING = 2'd0,
    READY   = 2'd1,
    FAULT   = 2'd2
  } ld_state_e;

  localparam int EXTRA_DEF  = 4;
  localparam int WORD_BYTES = 2**EXTRA_DEF;

  function automatic int word_bytes(input int extra);
    return 2**extra;
  endfunction

endpackage

// File: rtl/code_mem_loader_byte_ram.sv
// Byte-wide storage with one write port and a combinational window of
// 2**EXTRA consecutive bytes starting at raddr (wraps within the array).
module code_mem_loader_byte_ram
  import code_mem_loader_pkg::*;
#(
  parameter int AW    = 6,
  parameter int EXTRA = EXTRA_DEF,
  parameter int DW    = 8
) (
  input  logic                                     clk,
  input  logic                                     i_we,
  input  logic [AW-1:0]                            i_waddr,
  input  logic [DW-1:0]                            i_wdata,
  input  logic [AW-1:0]                            i_raddr,
  output logic [word_bytes(EXTRA)-1:0][DW-1:0]     o_win
);

  localparam int WB = word_bytes(EXTRA);

  // No reset: contents survive reset; the parent's length gates visibility.
  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  for (genvar i = 0; i < WB; i++) begin : g_win
    logic [AW-1:0] w_idx;
    assign w_idx    = i_raddr + AW'(i);
    assign o_win[i] = r_mem[w_idx];
  end

endmodule

// File: rtl/code_mem_loader.sv
// Writable code memory: loads a byte-stream image, holds the core in reset
// until complete, then serves bounded reads with one cycle of latency.
module code_mem_loader
  import code_mem_loader_pkg::*;
#(
  parameter int AW    = 6,
  parameter int EXTRA = EXTRA_DEF,
  parameter int DW    = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DW-1:0]                     load_data,
  input  logic                              load_valid,
  input  logic                              load_last,
  output logic                              load_ready,
  output logic                              loaded,
  output logic                              load_error,
  output logic                              core_reset,
  input  logic [AW:0]                       addr,
  input  logic [EXTRA-1:0]                  extra,
  input  logic [AW:0]                       lower_bound,
  input  logic [AW:0]                       upper_bound,
  output logic [word_bytes(EXTRA)*DW-1:0]   data,
  output logic                              error
);

  localparam int           WB       = word_bytes(EXTRA);
  localparam int           LW       = AW + 1;
  localparam logic [AW:0]  LEN_FULL = LW'(2**AW);

  ld_state_e               r_state, w_next;
  logic [AW:0]             r_len;
  logic                    w_xfer, w_full, w_we;
  logic [AW+1:0]           w_end;
  logic                    w_rd_err;
  logic [WB-1:0][DW-1:0]   w_win, w_gated;
  logic [WB*DW-1:0]        r_data;
  logic                    r_error;

  assign w_xfer = load_valid && load_ready;
  assign w_full = (r_len == LEN_FULL);
  assign w_we   = w_xfer && !w_full;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= LOADING;
    else       r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOADING: if (w_xfer) begin
        if (w_full)         w_next = FAULT;
        else if (load_last) w_next = READY;
      end
      READY:   w_next = READY;
      FAULT:   w_next = FAULT;
      default: w_next = LOADING;
    endcase
  end

  // FSM: outputs, decoded from the registered state
  always_comb begin
    load_ready = 1'b0;
    loaded     = 1'b0;
    load_error = 1'b0;
    core_reset = 1'b1;
    case (r_state)
      LOADING: load_ready = 1'b1;
      READY:   begin loaded = 1'b1; core_reset = 1'b0; end
      FAULT:   load_error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_len <= '0;
    else if (w_we) r_len <= r_len + 1'b1;
  end

  code_mem_loader_byte_ram #(.AW(AW), .EXTRA(EXTRA), .DW(DW)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_len[AW-1:0]),
    .i_wdata (load_data),
    .i_raddr (addr[AW-1:0]),
    .o_win   (w_win)
  );

  // One extra bit on end so addr+extra never wraps past the bound checks.
  assign w_end    = {1'b0, addr} + (AW+2)'(extra);
  assign w_rd_err = (r_state != READY)
                 || (addr < lower_bound)
                 || (w_end > {1'b0, upper_bound})
                 || (w_end >= {1'b0, r_len});

  for (genvar i = 0; i < WB; i++) begin : g_mask
    assign w_gated[i] = (EXTRA'(i) <= extra) ? w_win[i] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_error <= 1'b1;
    end else begin
      r_error <= w_rd_err;
      r_data  <= w_rd_err ? '0 : w_gated;
    end
  end

  assign data  = r_data;
  assign error = r_error;

endmodule

// File: tb/tb_code_mem_loader.sv
// Directed bench for code_mem_loader: load, bounded reads, backpressure,
// overflow and asynchronous reset.
module tb_code_mem_loader;

  localparam int AW = 6, EXTRA = 4, DW = 8, WB = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       load_data;
  logic             load_valid, load_last;
  logic             load_ready, loaded, load_error, core_reset;
  logic [AW:0]      addr, lower_bound, upper_bound;
  logic [EXTRA-1:0] extra;
  logic [WB*8-1:0]  data;
  logic             error;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [AW:0]      a;
    logic [EXTRA-1:0] x;
    logic [AW:0]      lb;
    logic [AW:0]      ub;
    logic             err;
    logic [127:0]     dat;
  } vec_t;

  vec_t vt[12];

  code_mem_loader #(.AW(AW), .EXTRA(EXTRA), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .load_data(load_data), .load_valid(load_valid), .load_last(load_last),
    .load_ready(load_ready), .loaded(loaded), .load_error(load_error),
    .core_reset(core_reset),
    .addr(addr), .extra(extra), .lower_bound(lower_bound), .upper_bound(upper_bound),
    .data(data), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},   128'(load_ready), 128'd1);
    chk({tag, "_loaded"},  128'(loaded),     128'd0);
    chk({tag, "_lderr"},   128'(load_error), 128'd0);
    chk({tag, "_corerst"}, 128'(core_reset), 128'd1);
    chk({tag, "_data"},    data,             128'd0);
    chk({tag, "_error"},   128'(error),      128'd1);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic send(input logic [7:0] d, input logic last);
    load_data  = d;
    load_valid = 1'b1;
    load_last  = last;
    @(posedge clk); @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 8'hC3;
  endtask

  task automatic rd(input logic [AW:0] a, input logic [EXTRA-1:0] x,
                    input logic [AW:0] lb, input logic [AW:0] ub);
    addr = a; extra = x; lower_bound = lb; upper_bound = ub;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  initial begin
    logic [7:0] img [8];
    img = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h01, 8'h00, 8'h00, 8'h00};

    vt[0]  = '{7'd0,  4'd3, 7'd0, 7'd127, 1'b0, 128'h6D736100};
    vt[1]  = '{7'd6,  4'd3, 7'd0, 7'd127, 1'b1, 128'h0};
    vt[2]  = '{7'd4,  4'd3, 7'd0, 7'd127, 1'b0, 128'h00000001};
    vt[3]  = '{7'd0,  4'd7, 7'd0, 7'd127, 1'b0, 128'h000000016D736100};
    vt[4]  = '{7'd1,  4'd0, 7'd0, 7'd127, 1'b0, 128'h61};
    vt[5]  = '{7'd0,  4'd8, 7'd0, 7'd127, 1'b1, 128'h0};
    vt[6]  = '{7'd1,  4'd0, 7'd2, 7'd127, 1'b1, 128'h0};
    vt[7]  = '{7'd2,  4'd0, 7'd2, 7'd127, 1'b0, 128'h73};
    vt[8]  = '{7'd4,  4'd2, 7'd0, 7'd5,   1'b1, 128'h0};
    vt[9]  = '{7'd4,  4'd1, 7'd0, 7'd5,   1'b0, 128'h0001};
    vt[10] = '{7'd64, 4'd0, 7'd0, 7'd127, 1'b1, 128'h0};
    vt[11] = '{7'd3,  4'd1, 7'd0, 7'd127, 1'b0, 128'h016D};

    reset = 1'b1; load_data = '0; load_valid = 1'b0; load_last = 1'b0;
    addr = '0; extra = '0; lower_bound = '0; upper_bound = 7'd127;
    #3;
    chk_reset_vals("por");
    @(negedge clk); reset = 1'b0;

    // Main image load; final byte carries a read that must still fault.
    for (int i = 0; i < 7; i++) send(img[i], 1'b0);
    chk("preload_loaded",  128'(loaded),     128'd0);
    chk("preload_corerst", 128'(core_reset), 128'd1);
    addr = 7'd0; extra = 4'd3;
    send(img[7], 1'b1);
    chk("last_loaded",   128'(loaded),     128'd1);
    chk("last_corerst",  128'(core_reset), 128'd0);
    chk("last_ready",    128'(load_ready), 128'd0);
    chk("same_cyc_err",  128'(error),      128'd1);
    chk("same_cyc_data", data,             128'd0);

    // Traffic after READY is ignored.
    send(8'hFF, 1'b1);
    send(8'hFE, 1'b0);
    chk("ready_hold_loaded", 128'(loaded),     128'd1);
    chk("ready_hold_lderr",  128'(load_error), 128'd0);

    for (int i = 0; i < 12; i++) begin
      rd(vt[i].a, vt[i].x, vt[i].lb, vt[i].ub);
      chk($sformatf("vec%0d_err", i),  128'(error), 128'(vt[i].err));
      chk($sformatf("vec%0d_data", i), data,        vt[i].dat);
    end

    // Asynchronous reset from READY, mid low phase.
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_ready");
    @(negedge clk); reset = 1'b0;

    // Backpressure: three bytes separated by idle cycles, reads fault throughout.
    addr = 7'd0; extra = 4'd0; lower_bound = 7'd0; upper_bound = 7'd127;
    send(8'h11, 1'b0);
    chk("bp_err0", 128'(error), 128'd1);
    idle(2);
    send(8'h22, 1'b0);
    chk("bp_err1", 128'(error), 128'd1);
    idle(1);
    send(8'h33, 1'b0);
    chk("bp_err2", 128'(error), 128'd1);
    chk("bp_loaded", 128'(loaded), 128'd0);
    send(8'h44, 1'b1);
    rd(7'd0, 4'd3, 7'd0, 7'd127);
    chk("bp_word_err",  128'(error), 128'd0);
    chk("bp_word_data", data,        128'h44332211);
    rd(7'd1, 4'd3, 7'd0, 7'd127);
    chk("bp_len_err",   128'(error), 128'd1);

    // Overflow: 64 bytes fit, 65th (with last) faults.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 64; i++) send(8'(i ^ 8'h5A), 1'b0);
    chk("full_ready",  128'(load_ready), 128'd1);
    chk("full_lderr",  128'(load_error), 128'd0);
    send(8'hEE, 1'b1);
    chk("ovf_lderr",   128'(load_error), 128'd1);
    chk("ovf_ready",   128'(load_ready), 128'd0);
    chk("ovf_loaded",  128'(loaded),     128'd0);
    chk("ovf_corerst", 128'(core_reset), 128'd1);
    send(8'h01, 1'b1);
    rd(7'd0, 4'd0, 7'd0, 7'd127);
    chk("ovf_rd_err",  128'(error), 128'd1);
    chk("ovf_rd_data", data,        128'd0);

    // Mid-load asynchronous reset, then a short reload.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 4; i++) send(img[i], 1'b0);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_load");
    @(negedge clk); reset = 1'b0;
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    rd(7'd2, 4'd0, 7'd0, 7'd127);
    chk("reload_len_err", 128'(error), 128'd1);
    rd(7'd0, 4'd1, 7'd0, 7'd127);
    chk("reload_err",  128'(error), 128'd0);
    chk("reload_data", data,        128'hBBAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/code_mem_loader.md
Name: code_mem_loader

Overview:
- Writable code memory: the producer end of the core's instruction/data memory interface, replacing the fixed-image ROM.
- Accepts a program image as a byte stream (valid/ready) and stores it in on-chip RAM.
- Holds the core in reset until loading completes.
- Then answers core reads with the same addr/extra/bounds → data/error contract as the ROM, one cycle latency.

Parameters:
- AW, 6, byte address width; storage depth 2**AW bytes; address ports are AW+1 bits so out-of-range addresses are detectable.
- EXTRA, 4, width of the extra (length-1) field; read word is 2**EXTRA bytes.
- DW, 8, storage element width in bits; only 8 is supported.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- load_data  in  8  image byte.
- load_valid  in  1  load_data valid.
- load_last  in  1  current byte is the final byte of the image.
- load_ready  out  1  loader accepts a byte this cycle.
- loaded  out  1  image complete, read port live.
- load_error  out  1  image exceeded 2**AW bytes.
- core_reset  out  1  reset for the core; high until loaded.
- addr  in  AW+1  read start byte address.
- extra  in  EXTRA  number of bytes to read minus one.
- lower_bound  in  AW+1  lowest legal address.
- upper_bound  in  AW+1  highest legal address.
- data  out  2**EXTRA*8  read data, little-endian, byte 0 = mem[addr].
- error  out  1  read fault.

Behaviour:
- Reset, asynchronous, all outputs and state:
  - state=LOADING, length=0, load_ready=1.
  - loaded=0, load_error=0, core_reset=1, data=0, error=1.
- Reset mid-load discards the partial image: length returns to 0.
- FSM states LOADING, READY, FAULT.
- LOADING:
  - A byte transfers when load_valid && load_ready at a rising clk: mem[length] <= load_data, length <= length+1.
  - Transfer with load_last=1 → READY next cycle.
  - Transfer when length == 2**AW (the byte would not fit) → FAULT; the byte is not written.
  - load_last with that overflowing byte → FAULT.
  - load_valid without load_ready is ignored.
- READY: load_ready=0, loaded=1, core_reset=0 (registered, deasserts the cycle after the last transfer). Further load traffic is ignored. Exit only via reset.
- FAULT: load_ready=0, load_error=1, loaded=0, core_reset stays 1. Exit only via reset.
- A zero-length image is impossible: the first transfer with load_last gives length=1.
- Read port, synchronous, 1-cycle latency: data/error are registered from addr/extra sampled at the rising clk.
- end = addr + extra, computed in AW+2 bits with no wrap.
- error=1 if any of the following hold:
  - state != READY;
  - addr < lower_bound;
  - end > upper_bound;
  - end >= length.
- When error=1, data=0.
- When error=0:
  - data byte i (0 ≤ i ≤ extra) = mem[addr+i];
  - bytes extra+1 .. 2**EXTRA-1 = 0.
- Reads in the same cycle as the final load transfer see loaded=0 and return error=1. The first valid read sample is the cycle after loaded rises.
- Memory contents persist across reads. Reset does not clear the RAM array, only length, which makes the old contents unreachable.

Decomposition:
- Shared core package (the one defining `i64`, `ENDED` etc.) gains:
  - loader state enum {LOADING, READY, FAULT};
  - localparam for read word bytes, 2**EXTRA.
- One sub-module, byte_ram:
  - 2**AW × 8 storage, one write port;
  - 2**EXTRA-byte combinational gather window, registered by the parent.

Test Plan:
- Load image 8'h00,8'h61,8'h73,8'h6D,8'h01,8'h00,8'h00,8'h00 (last on 8th), bounds 0/127 → loaded=1 and core_reset=0 on the cycle after the 8th transfer; read addr=0 extra=3 → next cycle data[31:0]=32'h6D736100, upper bytes 0, error=0.
- After that load, read addr=6 extra=3 (end=9 ≥ length 8) → error=1, data=0; read addr=4 extra=3 → data[31:0]=32'h00000001, error=0.
- Bounds: lower_bound=2, read addr=1 extra=0 → error=1; upper_bound=5, read addr=4 extra=2 → error=1; addr=4 extra=1 → error=0.
- Backpressure/idle: load_valid toggling 1,0,1 with gaps over 3 bytes → exactly 3 writes, length=3. Read attempted before last → error=1 throughout.
- Overflow (AW=6): stream 65 bytes without load_last → 65th byte not written, load_error=1, load_ready=0, core_reset stays 1, all reads error=1.
- Assert reset asynchronously after 4 of 8 bytes, mid-cycle → outputs at reset values immediately. Reload 2 bytes with last → length=2; read addr=2 extra=0 → error=1.
